vlc_run_encoder: RTL and testbench

- Parametrised successor to the VLC single-bit run counter. Accepts a stream of SYM_W-bit symbols over a valid/ready handshake.
- Detects runs of identical symbols and emits one (symbol, run_length, last) token per run.
- Splits runs that exceed the counter range, and closes runs on packet end or, optionally, on an input valid gap.
- Tokens are buffered in an internal FWFT FIFO with valid/ready output, feeding the downstream VLC code-word packer.

---
 rtl/vlc_run_encoder.sv | 193 +++++++++++++++++++
 tb/tb_vlc_run_encoder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vlc_run_encoder.sv
// vlc_run_encoder
// Run-length tokeniser for the VLC path. It groups runs of identical
// SYM_W-bit symbols into (symbol, run_length, last) tokens. Runs are split
// when they reach MAX_RUN, and closed on packet end or, optionally, on an
// input valid gap. Tokens are queued in a small first-word-fall-through FIFO
// that feeds the downstream code-word packer.
module vlc_run_encoder #(
    parameter int SYM_W      = 1,
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter bit GAP_CLOSE  = 1'b1,
    parameter int TP         = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SYM_W-1:0]              din,
    input  logic                          din_valid,
    input  logic                          din_last,
    output logic                          din_ready,
    output logic [SYM_W-1:0]              dout_sym,
    output logic [CNT_W-1:0]              dout_len,
    output logic                          dout_last,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int TOK_W = SYM_W + CNT_W + 1;
    localparam logic [CNT_W-1:0] MAX_RUN = {CNT_W{1'b1}};
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

    // TP is the register delay of the legacy behavioural model; the
    // synthesizable registers here carry no delay, so it is only range-checked.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        SYM_W < 1 || CNT_W < 1 || TP < 0) begin : g_param_check
        $error("vlc_run_encoder: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t             state_reg;
    logic [SYM_W-1:0]   run_sym_reg;
    logic [CNT_W-1:0]   run_cnt_reg;

    logic [TOK_W-1:0]   mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [LVL_W-1:0]   level_reg;

    logic               fifo_full;
    logic               accept;
    logic               pop;
    logic               push_en;
    logic [SYM_W-1:0]   push_sym;
    logic [CNT_W-1:0]   push_len;
    logic               push_last;
    logic [TOK_W-1:0]   head_tok;

    // Handshake terms, all derived from registered state only.
    assign fifo_full  = (level_reg == DEPTH_L);
    assign din_ready  = (state_reg != ST_FLUSH) && !fifo_full;
    assign accept     = din_valid && din_ready;
    assign dout_valid = (level_reg != '0);
    assign pop        = dout_valid && dout_ready;
    assign fifo_level = level_reg;

    // Decide whether this cycle closes a run and, if so, which token it emits.
    always_comb begin
        push_en   = 1'b0;
        push_sym  = run_sym_reg;
        push_len  = run_cnt_reg;
        push_last = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (accept && din_last) begin
                    push_en   = 1'b1;
                    push_sym  = din;
                    push_len  = CNT_W'(1);
                    push_last = 1'b1;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (din != run_sym_reg) begin
                        push_en = 1'b1;
                    end else if (run_cnt_reg == MAX_RUN) begin
                        push_en = 1'b1;
                    end else if (din_last) begin
                        push_en   = 1'b1;
                        push_len  = run_cnt_reg + CNT_W'(1);
                        push_last = 1'b1;
                    end
                end else if (GAP_CLOSE && !din_valid && !fifo_full) begin
                    push_en = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (!fifo_full) begin
                    push_en   = 1'b1;
                    push_last = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Run tracking FSM: open, extend, split and close runs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            run_sym_reg <= '0;
            run_cnt_reg <= '0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        run_sym_reg <= din;
                        run_cnt_reg <= CNT_W'(1);
                        state_reg   <= din_last ? ST_IDLE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (din != run_sym_reg) begin
                            // Symbol change: previous run already pushed, new one opens.
                            run_sym_reg <= din;
                            run_cnt_reg <= CNT_W'(1);
                            state_reg   <= din_last ? ST_FLUSH : ST_RUN;
                        end else if (run_cnt_reg == MAX_RUN) begin
                            // Split: full-length chunk pushed, this symbol starts a new chunk.
                            run_cnt_reg <= CNT_W'(1);
                            state_reg   <= din_last ? ST_FLUSH : ST_RUN;
                        end else begin
                            run_cnt_reg <= run_cnt_reg + CNT_W'(1);
                            state_reg   <= din_last ? ST_IDLE : ST_RUN;
                        end
                    end else if (push_en) begin
                        // Gap close succeeded.
                        state_reg <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    if (!fifo_full) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Token storage: each entry loads when the write pointer selects it.
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_mem
        always_ff @(posedge clk) begin
            if (push_en && (wr_ptr_reg == PTR_W'(gi))) begin
                mem_reg[gi] <= {push_sym, push_len, push_last};
            end
        end
    end

    // FIFO pointers and occupancy; push and pop together keep the level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (push_en && !pop) begin
                level_reg <= level_reg + LVL_W'(1);
            end else if (!push_en && pop) begin
                level_reg <= level_reg - LVL_W'(1);
            end
        end
    end

    // Fall-through head of the FIFO; forced to zero while empty so outputs
    // read as all-zero out of reset.
    assign head_tok = dout_valid ? mem_reg[rd_ptr_reg] : '0;
    assign {dout_sym, dout_len, dout_last} = head_tok;

endmodule

// File: tb/tb_vlc_run_encoder.sv
// tb_vlc_run_encoder
// Directed stimulus with a token scoreboard: expected tokens are queued as
// stimulus is issued and a negedge monitor compares each popped token.
module tb_vlc_run_encoder;

    typedef struct packed {
        logic [1:0] sym;
        logic [2:0] len;
        logic       last;
    } tok_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] din = '0;
    logic       din_valid = 1'b0;
    logic       din_last = 1'b0;
    logic       din_ready;
    logic [1:0] dout_sym;
    logic [2:0] dout_len;
    logic       dout_last;
    logic       dout_valid;
    logic       dout_ready = 1'b1;
    logic [2:0] fifo_level;

    int   n_vec = 0;
    int   n_err = 0;
    tok_t exp_q[$];
    tok_t exp_tok;

    vlc_run_encoder #(
        .SYM_W(2), .CNT_W(3), .FIFO_DEPTH(4), .GAP_CLOSE(1'b1), .TP(1)
    ) dut (
        .clk(clk), .rst(rst),
        .din(din), .din_valid(din_valid), .din_last(din_last), .din_ready(din_ready),
        .dout_sym(dout_sym), .dout_len(dout_len), .dout_last(dout_last),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: every token that is popped is checked against the scoreboard.
    always @(negedge clk) begin
        if (rst && dout_valid && dout_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL token: got unexpected (%0d,%0d,%0d), required none",
                         dout_sym, dout_len, dout_last);
            end else begin
                exp_tok = exp_q.pop_front();
                if ({dout_sym, dout_len, dout_last} !== exp_tok) begin
                    n_err++;
                    $display("FAIL token: got (%0d,%0d,%0d), required (%0d,%0d,%0d)",
                             dout_sym, dout_len, dout_last,
                             exp_tok.sym, exp_tok.len, exp_tok.last);
                end else begin
                    $display("token ok (%0d,%0d,%0d)", dout_sym, dout_len, dout_last);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic expect_tok(input logic [1:0] s, input logic [2:0] l, input logic last);
        exp_q.push_back('{sym: s, len: l, last: last});
    endtask

    // Present one symbol and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic send(input logic [1:0] s, input logic l);
        din       = s;
        din_valid = 1'b1;
        din_last  = l;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (din_ready) begin
                @(posedge clk);
                #1;
                din_valid = 1'b0;
                din_last  = 1'b0;
                $display("sent sym=%0d last=%0d", s, l);
                return;
            end
        end
        n_vec++;
        n_err++;
        $display("FAIL accept_timeout: got din_ready=0 for 200 cycles, required 1");
        din_valid = 1'b0;
        din_last  = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 200; t++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drain_pending", exp_q.size(), 0);
        chk("drain_valid", dout_valid, 0);
    endtask

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_fifo_level", fifo_level, 0);
        chk("rst_din_ready", din_ready, 1);
        chk("rst_dout_tok", {dout_sym, dout_len, dout_last}, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Runs closed by symbol change and by a valid gap.
        expect_tok(2'd1, 3'd3, 1'b0);
        expect_tok(2'd0, 3'd2, 1'b0);
        send(2'd1, 1'b0);
        send(2'd1, 1'b0);
        send(2'd1, 1'b0);
        send(2'd0, 1'b0);
        send(2'd0, 1'b0);
        chk("gap_not_yet", dout_valid, 0);
        @(posedge clk);
        #1;
        chk("gap_tok_valid", dout_valid, 1);
        chk("gap_tok_len", dout_len, 2);
        drain();

        // Run longer than MAX_RUN=7 is split.
        expect_tok(2'd2, 3'd7, 1'b0);
        expect_tok(2'd2, 3'd2, 1'b1);
        for (int i = 0; i < 9; i++) send(2'd2, (i == 8));
        drain();

        // Symbol change on the last symbol needs a FLUSH cycle.
        expect_tok(2'd3, 3'd2, 1'b0);
        expect_tok(2'd1, 3'd1, 1'b1);
        send(2'd3, 1'b0);
        send(2'd3, 1'b0);
        send(2'd1, 1'b1);
        chk("flush_ready", din_ready, 0);
        chk("flush_first_valid", dout_valid, 1);
        @(posedge clk);
        #1;
        chk("after_flush_ready", din_ready, 1);
        drain();

        // Back-pressure: FIFO fills, input stalls, then drains in order.
        dout_ready = 1'b0;
        expect_tok(2'd0, 3'd1, 1'b0);
        expect_tok(2'd1, 3'd1, 1'b0);
        expect_tok(2'd0, 3'd1, 1'b0);
        expect_tok(2'd1, 3'd1, 1'b0);
        expect_tok(2'd0, 3'd1, 1'b0);
        expect_tok(2'd1, 3'd1, 1'b0);
        for (int i = 0; i < 5; i++) send(2'(i % 2), 1'b0);
        chk("full_level", fifo_level, 4);
        chk("full_ready", din_ready, 0);
        fork
            send(2'd1, 1'b0);
            begin
                repeat (2) @(posedge clk);
                #1;
                chk("stall_level", fifo_level, 4);
                chk("stall_ready", din_ready, 0);
                chk("stall_head", {dout_valid, dout_sym, dout_len, dout_last}, 32'b1_00_001_0);
                dout_ready = 1'b1;
            end
        join
        drain();

        // Asynchronous reset mid-run discards buffered tokens and the open run.
        dout_ready = 1'b0;
        send(2'd1, 1'b0);
        send(2'd2, 1'b0);
        for (int i = 0; i < 5; i++) send(2'd3, 1'b0);
        chk("pre_rst_level", fifo_level, 2);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", dout_valid, 0);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_ready", din_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        dout_ready = 1'b1;
        expect_tok(2'd0, 3'd1, 1'b1);
        send(2'd0, 1'b1);
        drain();

        // Single-symbol packet from IDLE: no FLUSH cycle.
        expect_tok(2'd3, 3'd1, 1'b1);
        send(2'd3, 1'b1);
        chk("single_ready", din_ready, 1);
        chk("single_valid", dout_valid, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
